// File: rtl/hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
//
// Decode-stage hazard detector for the 5-stage MIPS pipeline. It catches the
// hazards that EX-stage forwarding cannot resolve:
//   - load-use dependencies (one bubble while the load reaches MEM)
//   - HI/LO and mult/div-unit hazards while a multi-cycle op is in flight
//   - control flush when a branch/jump resolves taken in EX
//
// Parameters
//   RSIZE   register address width
//   MD_LAT  mult/div latency in cycles after issue (>= 1)
//   CNT_W   width of the optional stall statistics counters
//
// Ports
//   clk, rst_n           pipeline clock (rising edge), async active-low reset
//   ID_Valid             IF/ID holds a real instruction
//   ID_RAddr1/2          rs / rt addresses of the ID instruction
//   ID_Use1/2            ID instruction actually reads rs / rt
//   ID_MulDiv            ID instruction is mult/multu/div/divu
//   ID_ReadHiLo          ID instruction is mfhi/mflo
//   EX_WAddr             destination register of the EX instruction
//   EX_MemRead           EX instruction is a load
//   BranchTaken          branch/jump resolved taken in EX this cycle
//   PC_Stall, IFID_Stall hold PC and IF/ID
//   IFID_Flush           clear IF/ID to a bubble
//   IDEX_Bubble          insert a bubble into ID/EX
//   MD_Busy              mult/div occupied, HI/LO not yet valid
//   LU_StallCnt          (HAZARD_STATS_EN) saturating count of load-use stalls
//   MD_StallCnt          (HAZARD_STATS_EN) saturating count of mult/div stalls
//
// Build option
//   `define HAZARD_STATS_EN to add the two statistics counters and ports.
// ---------------------------------------------------------------------------
module hazard_detect_unit #(
    parameter int RSIZE  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_Valid,
    input  logic [RSIZE-1:0] ID_RAddr1,
    input  logic [RSIZE-1:0] ID_RAddr2,
    input  logic             ID_Use1,
    input  logic             ID_Use2,
    input  logic             ID_MulDiv,
    input  logic             ID_ReadHiLo,
    input  logic [RSIZE-1:0] EX_WAddr,
    input  logic             EX_MemRead,
    input  logic             BranchTaken,
    output logic             PC_Stall,
    output logic             IFID_Stall,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MD_Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] LU_StallCnt,
    output logic [CNT_W-1:0] MD_StallCnt
`endif
);

    localparam int MD_W = $clog2(MD_LAT + 1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [MD_W-1:0] md_cnt;
    logic            load_use;
    logic            md_haz;
    logic            stall;
    logic            issue;

    // ---- ID stage: combinational hazard decode ----
    // Writes to $zero never create a dependency, so EX_WAddr==0 is ignored.
    assign load_use = EX_MemRead && (EX_WAddr != '0) && ID_Valid &&
                      ((ID_Use1 && (ID_RAddr1 == EX_WAddr)) ||
                       (ID_Use2 && (ID_RAddr2 == EX_WAddr)));

    assign md_haz = (md_cnt != '0) && ID_Valid && (ID_ReadHiLo || ID_MulDiv);

    // A taken branch squashes the ID instruction, so stalling it is pointless.
    assign stall = (load_use || md_haz) && !BranchTaken;
    assign issue = ID_Valid && ID_MulDiv && !stall && !BranchTaken;

    assign PC_Stall    = stall;
    assign IFID_Stall  = stall;
    assign IFID_Flush  = BranchTaken;
    assign IDEX_Bubble = stall || BranchTaken;
    assign MD_Busy     = (md_cnt != '0);

    // ---- mult/div occupancy counter ----
    // md_haz blocks a second issue while busy, so a reload never interrupts
    // a count and the decrement never runs below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (issue) begin
            md_cnt <= MD_W'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    // ---- stall statistics ----
    // One stall cycle is attributed to exactly one reason; load-use wins ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LU_StallCnt <= '0;
            MD_StallCnt <= '0;
        end else if (stall) begin
            if (load_use) begin
                LU_StallCnt <= sat_inc(LU_StallCnt);
            end else begin
                MD_StallCnt <= sat_inc(MD_StallCnt);
            end
        end
    end
`endif

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
Decode-stage hazard detector for the 5-stage MIPS pipeline. It sits upstream of the EX-stage operand forwarding logic and handles the hazards that forwarding cannot cover:
- load-use dependencies
- structural and data hazards on the multi-cycle mult/div unit (HI/LO)
- control flush on a taken branch resolved in EX

It drives the PC / IF-ID hold, the IF-ID flush and the ID-EX bubble controls, and tracks mult/div occupancy with an internal down-counter.

Parameters:
RSIZE, 5, register address width
MD_LAT, 4, mult/div latency in cycles after issue; legal range >=1
CNT_W, 32, width of optional stall statistics counters

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_Valid  input  1  IF/ID holds a real instruction (not a bubble)
ID_RAddr1  input  RSIZE  rs address of instruction in ID
ID_RAddr2  input  RSIZE  rt address of instruction in ID
ID_Use1  input  1  ID instruction reads rs
ID_Use2  input  1  ID instruction reads rt
ID_MulDiv  input  1  ID instruction is mult/multu/div/divu
ID_ReadHiLo  input  1  ID instruction is mfhi/mflo
EX_WAddr  input  RSIZE  destination register of instruction in EX
EX_MemRead  input  1  instruction in EX is a load
BranchTaken  input  1  branch/jump resolved taken in EX this cycle
PC_Stall  output  1  hold PC
IFID_Stall  output  1  hold IF/ID register
IFID_Flush  output  1  clear IF/ID register to bubble
IDEX_Bubble  output  1  load bubble (all write enables 0) into ID/EX
MD_Busy  output  1  mult/div unit occupied, HI/LO not yet valid

Behaviour:
- Reset:
  - rst_n low asynchronously clears MD_Cnt to 0 and the optional counters to 0.
  - With all inputs 0, every output is 0. No output is asserted purely because of reset.
- LoadUse = EX_MemRead && EX_WAddr!=0 && ID_Valid && ((ID_Use1 && ID_RAddr1==EX_WAddr) || (ID_Use2 && ID_RAddr2==EX_WAddr)).
- MDHaz = MD_Cnt!=0 && ID_Valid && (ID_ReadHiLo || ID_MulDiv).
- Stall = (LoadUse || MDHaz) && !BranchTaken. A taken branch has priority because the ID instruction is being squashed.
- Combinational outputs, same cycle:
  - PC_Stall = IFID_Stall = Stall
  - IFID_Flush = BranchTaken
  - IDEX_Bubble = Stall || BranchTaken
- Issue = ID_Valid && ID_MulDiv && !Stall && !BranchTaken.
- MD_Cnt, width clog2(MD_LAT+1), updated on the rising clk edge:
  - if Issue, load MD_LAT
  - else if MD_Cnt!=0, decrement by 1
  - else hold 0
- MD_Busy = MD_Cnt!=0.
- Issue while MD_Cnt!=0 is impossible: MDHaz stalls it. The counter therefore never reloads mid-count and never wraps below 0.
- Load-use latency: exactly one stall cycle. In the next cycle the load is in MEM and the forwarding path takes over.
- Mult/div latency: a dependent mfhi/mflo that follows the mult directly in ID stalls MD_LAT cycles. A non-HI/LO instruction never stalls on MD_Busy.
- Simultaneous LoadUse and MDHaz: one Stall, counted once per cycle. Reason priority for statistics is LoadUse.
- BranchTaken in the same cycle as a mult/div in ID: no issue and no counter load. A count already in progress continues; the in-flight op is older than the branch.
- Reset mid-count: MD_Cnt drops to 0 immediately. MD_Busy deasserts without waiting for clk.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds outputs LU_StallCnt and MD_StallCnt (CNT_W each).
  - Each increments on a clk edge when Stall is 1 with reason LoadUse or MDHaz respectively.
  - LoadUse wins a tie.
  - Each saturates at all-ones. Async clear on rst_n.
- Undefined: the ports and registers are absent, and all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with MD_Cnt previously 3 -> MD_Busy=0 immediately; all outputs 0 with inputs 0.
- Load-use, positive: EX_MemRead=1, EX_WAddr=8, ID_RAddr2=8, ID_Use2=1 -> PC_Stall=IFID_Stall=IDEX_Bubble=1 for 1 cycle.
- Load-use, negative: same with EX_WAddr=0 -> no stall. Same with ID_Use2=0 -> no stall.
- Mult/div: MD_LAT=4; mult issues at edge t, followed by mfhi in ID -> Stall high for 4 cycles, MD_Cnt 4,3,2,1,0, mfhi released when MD_Busy=0. An add after the mult -> no stall.
- Branch priority: BranchTaken=1 together with the LoadUse condition -> IFID_Flush=1, IDEX_Bubble=1, PC_Stall=0. With ID_MulDiv=1 -> MD_Cnt stays 0.
- Stats (HAZARD_STATS_EN): one load-use stall plus a 4-cycle mult/div stall -> LU_StallCnt=1, MD_StallCnt=4. Preloaded all-ones plus another stall -> value holds at all-ones.
